wm_block_blender: RTL and testbench

//  Streaming visible-watermark blender, parametrised successor of the block divider.

---
 rtl/wm_block_blender_if.sv | 32 +++
 rtl/wm_block_blender.sv | 212 +++++++++++++++++++++
 tb/tb_wm_block_blender.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wm_block_blender_if.sv
`default_nettype none
// ============================================================================
//  Module      : wm_block_blender_if
//  Description : Pixel-stream bundle for the watermark blender. Carries the
//                input valid/ready channel and the output valid/ready/last
//                channel.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wm_block_blender_if #(
    parameter int DATA_W = 8
) ();
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    // Stimulus / sink side: feeds pixels in, consumes blended pixels.
    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    // Blender side: consumes pixels, produces blended pixels.
    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface
`default_nettype wire

// File: rtl/wm_block_blender.sv
`default_nettype none
// ============================================================================
//  Module      : wm_block_blender
//  Description : Streaming visible-watermark blender. Loads an MxM primary
//                block and the matching MxM watermark block, derives mean and
//                gradient statistics, computes blend coefficients and streams
//                sat((ak*P + bk*W) >> 7).
//  Revision    : 1.0 - initial release
// ============================================================================
module wm_block_blender #(
    parameter  int DATA_W = 8,
    parameter  int MAX_M  = 8,
    localparam int IDX_W  = $clog2(MAX_M * MAX_M)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [IDX_W-1:0]  cfg_m,
    input  wire logic [DATA_W:0]   cfg_bthr,
    input  wire logic [7:0]        cfg_amin,
    input  wire logic [7:0]        cfg_amax,
    input  wire logic [7:0]        cfg_bmin,
    input  wire logic [7:0]        cfg_bmax,
    wm_block_blender_if.slave      bus,
    output logic                   busy,
    output logic                   err
);
    localparam int N_MAX  = MAX_M * MAX_M;
    localparam int ACC_W  = 2 * $clog2(MAX_M) + DATA_W + 2;
    localparam int CNT_W  = $clog2(ACC_W + 1);
    localparam int PROD_W = DATA_W + 10;
    localparam int BL_W   = DATA_W + 9;
    localparam logic [DATA_W-1:0] WHITE = '1;
    localparam logic [DATA_W:0]   MID   = {2'b01, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD_P, LOAD_W, DIV, COEF, OUT} state_t;
    state_t state, state_nx;

    logic [DATA_W-1:0] p_mem [N_MAX];
    logic [DATA_W-1:0] w_mem [N_MAX];

    logic [IDX_W-1:0]  m_reg, idx, col, row;
    logic [IDX_W:0]    n_reg;
    logic [DATA_W:0]   bthr;
    logic [7:0]        amin, amax, bmin, bmax, ak, bk;
    logic [ACC_W-1:0]  sum_p, sum_g, quo_p, quo_g, rem_p, rem_g;
    logic [CNT_W-1:0]  div_cnt;
    logic              armed, err_q;

    logic              xfer_in, xfer_out, cfg_bad, last_idx;
    logic [IDX_W:0]    n_cfg;
    logic [DATA_W:0]   grad;
    logic [ACC_W:0]    trial_p, trial_g, div_x;
    logic              ge_p, ge_g;
    logic [DATA_W:0]   uk, dev;
    logic [PROD_W-1:0] a_prod, b_prod;
    logic [BL_W-1:0]   blend, blend_sh;

    function automatic logic [DATA_W-1:0] absdiff(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Handshake qualifiers, block-size decode and config validity.
    always_comb begin
        xfer_in  = bus.s_valid && bus.s_ready;
        xfer_out = bus.m_valid && bus.m_ready;
        n_cfg    = (IDX_W+1)'({1'b0, cfg_m} * {1'b0, cfg_m});
        cfg_bad  = (cfg_m == '0) || (cfg_m > IDX_W'(MAX_M)) ||
                   (cfg_amin > cfg_amax) || (cfg_bmin > cfg_bmax);
        last_idx = ({1'b0, idx} == (n_reg - (IDX_W+1)'(1)));
    end

    // Gradient contribution of the incoming primary pixel vs its left/up neighbours.
    always_comb begin
        grad = '0;
        if (col != '0)
            grad = grad + {1'b0, absdiff(bus.s_data, p_mem[idx - IDX_W'(1)])};
        if (row != '0)
            grad = grad + {1'b0, absdiff(bus.s_data, p_mem[idx - m_reg])};
    end

    // One restoring-division step for both dividends against the shared divisor N.
    always_comb begin
        div_x   = (ACC_W+1)'(n_reg);
        trial_p = {rem_p, quo_p[ACC_W-1]};
        trial_g = {rem_g, quo_g[ACC_W-1]};
        ge_p    = (trial_p >= div_x);
        ge_g    = (trial_g >= div_x);
    end

    // Coefficient products: distance of the block mean from mid-grey steers ak/bk.
    always_comb begin
        uk     = {1'b0, quo_p[DATA_W-1:0]};
        dev    = (uk >= MID) ? (uk - MID) : (MID - uk);
        a_prod = PROD_W'(amax - amin) * PROD_W'(MID - dev);
        b_prod = PROD_W'(bmax - bmin) * PROD_W'(dev);
    end

    // Output pixel: full-width weighted sum, then saturate to white.
    always_comb begin
        blend    = BL_W'(ak) * BL_W'(p_mem[idx]) + BL_W'(bk) * BL_W'(w_mem[idx]);
        blend_sh = blend >> 7;
        bus.m_valid = (state == OUT);
        bus.m_last  = (state == OUT) && last_idx;
        bus.m_data  = '0;
        if (state == OUT)
            bus.m_data = (blend_sh > BL_W'(WHITE)) ? WHITE : blend_sh[DATA_W-1:0];
        bus.s_ready = armed && ((state == IDLE) || (state == LOAD_P) || (state == LOAD_W));
        busy        = (state != IDLE);
        err         = err_q;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (xfer_in && !cfg_bad)
                         state_nx = (n_cfg == (IDX_W+1)'(1)) ? LOAD_W : LOAD_P;
            LOAD_P:  if (xfer_in && last_idx) state_nx = LOAD_W;
            LOAD_W:  if (xfer_in && last_idx) state_nx = DIV;
            DIV:     if (div_cnt == CNT_W'(ACC_W - 1)) state_nx = COEF;
            COEF:    state_nx = OUT;
            OUT:     if (xfer_out && last_idx) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Pixel buffers; contents are don't-care until overwritten by a new block.
    always_ff @(posedge clk) begin
        if (state == IDLE && xfer_in && !cfg_bad) p_mem[0]   <= bus.s_data;
        if (state == LOAD_P && xfer_in)           p_mem[idx] <= bus.s_data;
        if (state == LOAD_W && xfer_in)           w_mem[idx] <= bus.s_data;
    end

    // Datapath: config capture, statistics, division, coefficients, output index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed <= 1'b0;  err_q <= 1'b0;
            m_reg <= '0;    n_reg <= '0;    bthr <= '0;
            amin  <= '0;    amax  <= '0;    bmin <= '0;  bmax <= '0;
            idx   <= '0;    col   <= '0;    row  <= '0;
            sum_p <= '0;    sum_g <= '0;
            quo_p <= '0;    quo_g <= '0;    rem_p <= '0; rem_g <= '0;
            div_cnt <= '0;  ak <= '0;       bk <= '0;
        end else begin
            armed <= 1'b1;
            err_q <= 1'b0;
            case (state)
                IDLE: if (xfer_in) begin
                    m_reg <= cfg_m;    n_reg <= n_cfg;    bthr <= cfg_bthr;
                    amin  <= cfg_amin; amax  <= cfg_amax;
                    bmin  <= cfg_bmin; bmax  <= cfg_bmax;
                    if (cfg_bad) begin
                        err_q <= 1'b1;
                    end else begin
                        sum_p <= ACC_W'(bus.s_data);
                        sum_g <= '0;
                        idx   <= (n_cfg == (IDX_W+1)'(1)) ? '0 : IDX_W'(1);
                        col   <= IDX_W'(1);
                        row   <= '0;
                    end
                end
                LOAD_P: if (xfer_in) begin
                    sum_p <= sum_p + ACC_W'(bus.s_data);
                    sum_g <= sum_g + ACC_W'(grad);
                    idx   <= last_idx ? '0 : idx + IDX_W'(1);
                    if (col == m_reg - IDX_W'(1)) begin
                        col <= '0;
                        row <= row + IDX_W'(1);
                    end else begin
                        col <= col + IDX_W'(1);
                    end
                end
                LOAD_W: if (xfer_in) begin
                    if (last_idx) begin
                        idx     <= '0;
                        quo_p   <= sum_p;  quo_g <= sum_g;
                        rem_p   <= '0;     rem_g <= '0;
                        div_cnt <= '0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DIV: begin
                    rem_p   <= ge_p ? ACC_W'(trial_p - div_x) : ACC_W'(trial_p);
                    rem_g   <= ge_g ? ACC_W'(trial_g - div_x) : ACC_W'(trial_g);
                    quo_p   <= {quo_p[ACC_W-2:0], ge_p};
                    quo_g   <= {quo_g[ACC_W-2:0], ge_g};
                    div_cnt <= div_cnt + CNT_W'(1);
                end
                COEF: begin
                    if (quo_g >= ACC_W'(bthr)) begin
                        ak <= amax;
                        bk <= bmin;
                    end else begin
                        ak <= 8'(PROD_W'(amin) + (a_prod >> (DATA_W - 1)));
                        bk <= 8'(PROD_W'(bmin) + (b_prod >> (DATA_W - 1)));
                    end
                end
                OUT: if (xfer_out) idx <= last_idx ? '0 : idx + IDX_W'(1);
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_wm_block_blender.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wm_block_blender
//  Description : Directed and randomized checks of wm_block_blender against a
//                behavioural block-statistics / blend model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wm_block_blender;
    localparam int ACC_W = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] cfg_m = '0;
    logic [8:0] cfg_bthr = '0;
    logic [7:0] cfg_amin = '0, cfg_amax = '0, cfg_bmin = '0, cfg_bmax = '0;
    logic       busy, err;

    int tests = 0;
    int fails = 0;
    int pa [64];
    int wa [64];
    int ex [64];

    wm_block_blender_if #(.DATA_W(8)) bus ();

    wm_block_blender #(.DATA_W(8), .MAX_M(8)) dut (
        .clk(clk), .rst(rst),
        .cfg_m(cfg_m), .cfg_bthr(cfg_bthr),
        .cfg_amin(cfg_amin), .cfg_amax(cfg_amax),
        .cfg_bmin(cfg_bmin), .cfg_bmax(cfg_bmax),
        .bus(bus), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("comparison %s differs", tag);
        end
    endtask

    task automatic set_cfg(input int m, input int amin, input int amax,
                           input int bmin, input int bmax, input int bthr);
        cfg_m = 6'(m);  cfg_amin = 8'(amin); cfg_amax = 8'(amax);
        cfg_bmin = 8'(bmin); cfg_bmax = 8'(bmax); cfg_bthr = 9'(bthr);
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: mean, average gradient, coefficients and saturated blend.
    task automatic model(input int m);
        int n, sp, sg, uk, gk, dev, ak, bk, v, i;
        n = m * m; sp = 0; sg = 0;
        for (int r = 0; r < m; r++)
            for (int c = 0; c < m; c++) begin
                i = r * m + c;
                sp += pa[i];
                if (c > 0) sg += iabs(pa[i] - pa[i-1]);
                if (r > 0) sg += iabs(pa[i] - pa[i-m]);
            end
        uk = sp / n;
        gk = sg / n;
        if (gk >= int'(cfg_bthr)) begin
            ak = int'(cfg_amax);
            bk = int'(cfg_bmin);
        end else begin
            dev = iabs(uk - 128);
            ak = int'(cfg_amin) + (((int'(cfg_amax) - int'(cfg_amin)) * (128 - dev)) / 128);
            bk = int'(cfg_bmin) + (((int'(cfg_bmax) - int'(cfg_bmin)) * dev) / 128);
        end
        for (int k = 0; k < n; k++) begin
            v = (ak * pa[k] + bk * wa[k]) / 128;
            ex[k] = (v > 255) ? 255 : v;
        end
    endtask

    task automatic send_pix(input int d);
        int w = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'(d);
        while (bus.s_ready !== 1'b1 && w < 100) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 100) check("s_ready_wait", bus.s_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic recv_block(input int n, input bit stall);
        logic [7:0] hd;
        logic       hl;
        int         w;
        for (int i = 0; i < n; i++) begin
            w = 0;
            bus.m_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            while (!(bus.m_valid === 1'b1 && bus.m_ready === 1'b1) && w < 200) begin
                if (stall && bus.m_valid === 1'b1) begin
                    hd = bus.m_data;
                    hl = bus.m_last;
                    check("s_ready_out", bus.s_ready, 0);
                    @(posedge clk); #1;
                    check("stall_valid", bus.m_valid, 1);
                    check("stall_data", bus.m_data, hd);
                    check("stall_last", bus.m_last, hl);
                end else begin
                    @(posedge clk); #1;
                end
                w++;
                bus.m_ready = stall ? ($urandom_range(0, 1) != 0) : 1'b1;
            end
            if (w >= 200) check("out_wait", bus.m_valid, 1);
            check("m_data", bus.m_data, ex[i]);
            check("m_last", bus.m_last, (i == n - 1));
            check("s_ready_beat", bus.s_ready, 0);
            @(posedge clk); #1;
        end
        bus.m_ready = 1'b0;
        check("valid_after", bus.m_valid, 0);
        check("busy_after", busy, 0);
    endtask

    task automatic run_block(input int m, input bit stall);
        int n = m * m;
        int c;
        model(m);
        for (int i = 0; i < n; i++) send_pix(pa[i]);
        for (int i = 0; i < n; i++) send_pix(wa[i]);
        bus.s_valid = 1'b0;
        c = 1;
        while (bus.m_valid !== 1'b1 && c < 100) begin
            check("s_ready_div", bus.s_ready, 0);
            @(posedge clk); #1; c++;
        end
        check("latency", c, ACC_W + 2);
        recv_block(n, stall);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_s_ready"}, bus.s_ready, 0);
        check({tag, "_m_valid"}, bus.m_valid, 0);
        check({tag, "_m_data"},  bus.m_data, 0);
        check({tag, "_m_last"},  bus.m_last, 0);
        check({tag, "_busy"},    busy, 0);
        check({tag, "_err"},     err, 0);
    endtask

    task automatic reject(input string tag);
        send_pix(77);
        bus.s_valid = 1'b0;
        check({tag, "_err"}, err, 1);
        check({tag, "_busy"}, busy, 0);
        @(posedge clk); #1;
        check({tag, "_err_clr"}, err, 0);
        for (int k = 0; k < 3; k++) begin
            check({tag, "_no_out"}, bus.m_valid, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int m, base;
        bit smooth;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // T1
        set_cfg(1, 32, 96, 16, 64, 50);
        pa[0] = 100; wa[0] = 200;
        run_block(1, 0);

        // T2
        set_cfg(2, 32, 96, 16, 64, 50);
        for (int i = 0; i < 4; i++) begin pa[i] = 128; wa[i] = 0; end
        run_block(2, 0);

        // T3
        pa[0] = 0; pa[1] = 255; pa[2] = 255; pa[3] = 0;
        for (int i = 0; i < 4; i++) wa[i] = 255;
        run_block(2, 0);

        // T4
        set_cfg(1, 255, 255, 255, 255, 50);
        pa[0] = 255; wa[0] = 255;
        run_block(1, 0);

        // T5: T3 with random output stalls
        set_cfg(2, 32, 96, 16, 64, 50);
        pa[0] = 0; pa[1] = 255; pa[2] = 255; pa[3] = 0;
        for (int i = 0; i < 4; i++) wa[i] = 255;
        run_block(2, 1);

        // T6: reset while loading the watermark block
        for (int i = 0; i < 4; i++) send_pix(9);
        for (int i = 0; i < 2; i++) send_pix(33);
        bus.s_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_idle_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin pa[i] = 128; wa[i] = 0; end
        run_block(2, 0);

        // Rejected configurations
        set_cfg(0, 32, 96, 16, 64, 50);
        reject("m0");
        set_cfg(9, 32, 96, 16, 64, 50);
        reject("m9");
        set_cfg(2, 97, 96, 16, 64, 50);
        reject("aswap");
        set_cfg(2, 32, 96, 65, 64, 50);
        reject("bswap");

        // Randomized back-to-back blocks
        for (int t = 0; t < 12; t++) begin
            int amin, bmin;
            m    = int'($urandom_range(1, 8));
            amin = int'($urandom_range(0, 255));
            bmin = int'($urandom_range(0, 255));
            set_cfg(m, amin, int'($urandom_range(amin, 255)),
                    bmin, int'($urandom_range(bmin, 255)), int'($urandom_range(0, 300)));
            smooth = (t % 2) == 0;
            base   = int'($urandom_range(0, 255));
            for (int i = 0; i < m * m; i++) begin
                if (smooth) begin
                    pa[i] = base + int'($urandom_range(0, 16)) - 8;
                    if (pa[i] < 0)   pa[i] = 0;
                    if (pa[i] > 255) pa[i] = 255;
                end else begin
                    pa[i] = int'($urandom_range(0, 255));
                end
                wa[i] = int'($urandom_range(0, 255));
            end
            run_block(m, (t % 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
